// File: rtl/da_lut_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : da_lut_loader_if
// Purpose  : Bundles the host coefficient stream (start/coef_in/coef_valid/
//            coef_ready), the DA filter LUT write port (CIN/CADDR/CLOAD) and
//            the session status flags (busy/done) of the DA LUT loader.
// Modports : master - host/filter side (drives start, coef_in, coef_valid)
//            slave  - loader side (drives coef_ready, CIN, CADDR, CLOAD,
//                     busy, done)
// Revision : 1.0 - initial release
// ============================================================================
interface da_lut_loader_if #(
    parameter int COEF_W = 16,
    parameter int LUT_W  = 20,
    parameter int ADDR_W = 11
);
    logic              start;
    logic [COEF_W-1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic [LUT_W-1:0]  CIN;
    logic [ADDR_W-1:0] CADDR;
    logic              CLOAD;
    logic              busy;
    logic              done;

    modport master (
        output start, coef_in, coef_valid,
        input  coef_ready, CIN, CADDR, CLOAD, busy, done
    );

    modport slave (
        input  start, coef_in, coef_valid,
        output coef_ready, CIN, CADDR, CLOAD, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/da_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : da_lut_loader
// Purpose  : Coefficient-side initiator for the DA FIR filter. Collects 8 raw
//            signed taps per group from the host, then writes all 256
//            distributed-arithmetic partial sums of that group into the
//            filter LUT, one entry per cycle. NUM_GROUPS groups form one
//            session; done pulses once at the end.
// Ports    : clk            - filter fast clock
//            reset          - asynchronous, active-high reset
//            bus.start      - session request (honoured in IDLE only)
//            bus.coef_in    - signed raw coefficient, tap order 0..63
//            bus.coef_valid - coef_in valid
//            bus.coef_ready - loader accepts coef_in (high in COLLECT)
//            bus.CIN        - LUT entry data
//            bus.CADDR      - LUT entry address {group, k}
//            bus.CLOAD      - LUT write strobe
//            bus.busy       - session in progress
//            bus.done       - one-cycle end-of-session pulse
// Revision : 1.0 - initial release
// ============================================================================
module da_lut_loader #(
    parameter int COEF_W     = 16,
    parameter int LUT_W      = 20,
    parameter int NUM_GROUPS = 8,
    parameter int ADDR_W     = 11
) (
    input  wire logic         clk,
    input  wire logic         reset,
    da_lut_loader_if.slave    bus
);

    localparam int c_SUM_W = COEF_W + 3;   // 8 terms need 3 guard bits
    localparam int c_GRP_W = ADDR_W - 8;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_GEN     = 2'd2;

    localparam logic [c_GRP_W-1:0] c_LAST_GRP = c_GRP_W'(NUM_GROUPS - 1);

    logic [1:0]         r_state;
    logic [c_GRP_W-1:0] r_group;
    logic [2:0]         r_idx;
    logic [7:0]         r_k;
    logic               r_fin;
    logic [COEF_W-1:0]  r_buf [0:7];

    logic [LUT_W-1:0]   r_cin;
    logic [ADDR_W-1:0]  r_caddr;
    logic               r_cload;
    logic               r_busy;
    logic               r_done;

    logic [c_SUM_W-1:0] w_sum;
    logic [LUT_W-1:0]   w_sum_ext;

    // Partial sum for the current k: bit b of k selects tap 8*group+b.
    always_comb begin
        w_sum = '0;
        for (int b = 0; b < 8; b++) begin
            if (r_k[b]) begin
                w_sum = w_sum + {{3{r_buf[b][COEF_W-1]}}, r_buf[b]};
            end
        end
    end

    generate
        if (LUT_W > c_SUM_W) begin : g_sext_pad
            assign w_sum_ext = {{(LUT_W - c_SUM_W){w_sum[c_SUM_W-1]}}, w_sum};
        end else begin : g_sext_exact
            assign w_sum_ext = w_sum[LUT_W-1:0];
        end
    endgenerate

    assign bus.coef_ready = (r_state == c_ST_COLLECT);
    assign bus.CIN        = r_cin;
    assign bus.CADDR      = r_caddr;
    assign bus.CLOAD      = r_cload;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_group <= '0;
            r_idx   <= '0;
            r_k     <= '0;
            r_fin   <= 1'b0;
            r_cin   <= '0;
            r_caddr <= '0;
            r_cload <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_cload <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_ST_COLLECT;
                        r_group <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                c_ST_COLLECT: begin
                    // coef_ready is high throughout COLLECT, so valid alone
                    // marks a transfer.
                    if (bus.coef_valid) begin
                        r_buf[r_idx] <= bus.coef_in;
                        r_idx        <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= c_ST_GEN;
                            r_k     <= '0;
                        end
                    end
                end

                c_ST_GEN: begin
                    if (r_fin) begin
                        // Last entry of the final group is on the port now;
                        // retire the session as CLOAD drops.
                        r_fin   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cload <= 1'b1;
                        r_caddr <= {r_group, r_k};
                        r_cin   <= w_sum_ext;
                        r_k     <= r_k + 8'd1;
                        if (r_k == 8'hFF) begin
                            if (r_group == c_LAST_GRP) begin
                                r_fin <= 1'b1;
                            end else begin
                                r_state <= c_ST_COLLECT;
                                r_group <= r_group + 1'b1;
                                r_idx   <= '0;
                            end
                        end
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/da_lut_loader.md
Name: da_lut_loader

Overview:
Coefficient-side initiator for the DA FIR filter. It accepts raw signed tap coefficients from a host over a valid/ready stream. It precomputes every distributed-arithmetic partial-sum LUT entry and drives the filter's CIN/CADDR/CLOAD write port, one entry per cycle. One load session writes all 8 LUTs × 256 entries (64 taps) and then pulses done.

Parameters:
COEF_W, 16, signed raw tap coefficient width
LUT_W, 20, LUT entry width (CIN); must be ≥ COEF_W+3
NUM_GROUPS, 8, number of 8-tap groups/LUTs (CADDR[10:8] = group index)
ADDR_W, 11, CADDR width = log2(NUM_GROUPS)+8

Ports:
clk  in  1  system clock (filter fast clock domain)
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a load session; sampled only in IDLE
coef_in  in  COEF_W  signed raw coefficient, tap order 0..63
coef_valid  in  1  coef_in valid
coef_ready  out  1  loader accepts coef_in this cycle (transfer = valid & ready)
CIN  out  LUT_W  LUT entry data to filter
CADDR  out  ADDR_W  LUT entry address {group[2:0], k[7:0]}
CLOAD  out  1  write strobe; CIN/CADDR are valid when high
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end

Behaviour:
- Reset (async assert): state=IDLE; CIN=0, CADDR=0, CLOAD=0, coef_ready=0, busy=0, done=0. Group counter, entry counter and coefficient buffer are cleared. Reset mid-session abandons the session immediately; no further CLOAD; done is not pulsed.
- FSM states: IDLE, COLLECT, GEN.
- IDLE: when start=1 → COLLECT, group g=0, buffer index i=0. busy goes high the next cycle. start is ignored in every state other than IDLE.
- COLLECT: coef_ready=1 as a combinational function of state (high in COLLECT only). Each transfer stores coef_in into buf[i] and increments i. coef_valid gaps stall without limit. On the transfer with i=7: → GEN, k=0.
- GEN: coef_ready=0. Each cycle, registered outputs update: CLOAD<=1, CADDR<={g,k}, CIN<=sign-extended sum of buf[b] over all bits b with k[b]=1 (k=0 gives 0). k then increments.
  - CLOAD is high for exactly 256 consecutive cycles, starting the cycle after GEN entry.
  - Addresses are strictly ascending k=0..255 within a group.
- At k=255: if g<NUM_GROUPS-1, go to COLLECT with g+1 and i=0. Otherwise go to IDLE.
- CLOAD deasserts the cycle after the last entry is issued. In the final group, done=1 and busy=0 in that same cycle. done is high for one cycle only.
- Arithmetic: full-precision signed sum of up to 8 COEF_W terms (COEF_W+3 bits), sign-extended to LUT_W. No saturation is needed.
- Tap mapping: tap t = 8g+b; bit b of CADDR[7:0] selects tap 8g+b.
- Coefficients presented while in GEN or IDLE are not accepted; the host holds them.
- Minimum session length with continuous coef_valid: 8×(8+256)=2112 cycles from the first transfer to done.

Test Plan:
- All 64 coefficients = +1, continuous valid → 2048 CLOAD writes; CIN at CADDR {g,k} = popcount(k) (e.g. k=8'hFF → 8, k=8'h05 → 2); done pulses once; CLOAD count = 2048.
- All coefficients = -32768 → CIN at k=255 = 20'hC0000, at k=1 = 20'hF8000, at k=0 = 0, in every group.
- Group 3 taps = {1,2,4,...,128}, others 0 → for g=3, CIN = k at every k; all entries for other groups = 0.
- coef_valid toggled every other cycle → coef_ready/CLOAD sequence is identical apart from stall cycles; no duplicate or missing addresses.
- Reset asserted at g=2, k=100 → CLOAD=0 immediately, busy=0, no done. A new start then produces a full clean session from CADDR 0.
- start pulsed while busy → ignored; exactly one done per session.
